// File: rtl/reversible_serial_unadder_pkg.sv
// reversible_serial_unadder_pkg: shared FSM encoding and sizing helper for the reversible unadder.
package reversible_serial_unadder_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    function automatic int digit_count(input int width, input int digit);
        return width / digit;
    endfunction
endpackage

// File: rtl/feynman_gate.sv
// feynman_gate: reversible CNOT, control passes through and the target is XORed with it.
module feynman_gate (
    input  logic ctrl_i,
    input  logic tgt_i,
    output logic ctrl_o,
    output logic tgt_o
);
    assign ctrl_o = ctrl_i;
    assign tgt_o  = ctrl_i ^ tgt_i;
endmodule

// File: rtl/fredkin_gate.sv
// fredkin_gate: reversible controlled swap, x and y exchange places when ctrl is set.
module fredkin_gate (
    input  logic ctrl_i,
    input  logic x_i,
    input  logic y_i,
    output logic ctrl_o,
    output logic x_o,
    output logic y_o
);
    assign ctrl_o = ctrl_i;
    assign x_o    = ctrl_i ? y_i : x_i;
    assign y_o    = ctrl_i ? x_i : y_i;
endmodule

// File: rtl/unadder_slice.sv
// unadder_slice: one bit of the uncompute chain, recovers a = s^b^c and regenerates the forward carry.
module unadder_slice (
    input  logic s_i,
    input  logic b_i,
    input  logic c_i,
    output logic a_o,
    output logic c_o
);
    logic c_p, x, x_p, unused_ctrl, unused_swap;
    feynman_gate u_x (.ctrl_i(c_i), .tgt_i(s_i), .ctrl_o(c_p), .tgt_o(x));
    feynman_gate u_a (.ctrl_i(x), .tgt_i(b_i), .ctrl_o(x_p), .tgt_o(a_o));
    // a^b set means the forward carry propagated c, otherwise it was generated/killed by b
    fredkin_gate u_c (
        .ctrl_i(x_p), .x_i(c_p), .y_i(b_i),
        .ctrl_o(unused_ctrl), .x_o(unused_swap), .y_o(c_o)
    );
endmodule

// File: rtl/reversible_serial_unadder.sv
// reversible_serial_unadder: digit-serial recovery of A = Sum - B - Cin with carry-out self-check.
module reversible_serial_unadder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    input  logic             cout_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a_out,
    output logic             carry_mismatch
);
    import reversible_serial_unadder_pkg::*;
    localparam int N  = digit_count(WIDTH, DIGIT);
    localparam int CW = $clog2(N + 1);
    state_t state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d, b_q, b_d, acc_q, acc_d, a_q, a_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic carry_q, carry_d, cout_q, cout_d, mis_q, mis_d;
    logic [DIGIT:0] c;
    logic [DIGIT-1:0] a_dig;
    assign c[0] = carry_q;
    for (genvar i = 0; i < DIGIT; i++) begin : g_slice
        unadder_slice u_slice (
            .s_i(s_q[i]), .b_i(b_q[i]), .c_i(c[i]), .a_o(a_dig[i]), .c_o(c[i+1])
        );
    end
    assign in_ready       = state_q == IDLE;
    assign out_valid      = state_q == DONE;
    assign a_out          = a_q;
    assign carry_mismatch = mis_q;
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        b_d     = b_q;
        acc_d   = acc_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        mis_d   = mis_q;
        case (state_q)
            IDLE: if (in_valid) begin
                s_d     = sum_in;
                b_d     = b_in;
                cout_d  = cout_in;
                carry_d = cin_in;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                // operands shift down so the slices always see the current digit at bit 0
                s_d     = s_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = (acc_q >> DIGIT) | (WIDTH'(a_dig) << (WIDTH - DIGIT));
                carry_d = c[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    a_d     = acc_d;
                    mis_d   = c[DIGIT] != cout_q;
                    state_d = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            mis_q   <= mis_d;
        end
    end
endmodule

// File: tb/tb_reversible_serial_unadder.sv
// tb_reversible_serial_unadder: directed and randomized checks of the unadder against a forward-adder model.
module tb_reversible_serial_unadder;
    localparam int N = 8;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] sum_in = '0, b_in = '0;
    logic cin_in = 1'b0, cout_in = 1'b0;
    logic in_ready, out_valid, carry_mismatch;
    logic [31:0] a_out;
    logic v1 = 1'b0, v32 = 1'b0, rdy1, rdy32, ov1, ov32, m1, m32;
    logic [31:0] a1, a32;
    int n_tests = 0, n_fail = 0;
    logic [31:0] ra, rb;
    logic rc;
    bit flip;
    always #5 clk = ~clk;

    reversible_serial_unadder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sum_in(sum_in), .b_in(b_in), .cin_in(cin_in), .cout_in(cout_in),
        .out_valid(out_valid), .out_ready(out_ready), .a_out(a_out), .carry_mismatch(carry_mismatch)
    );
    reversible_serial_unadder #(.WIDTH(32), .DIGIT(1)) d1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1),
        .sum_in(sum_in), .b_in(b_in), .cin_in(cin_in), .cout_in(cout_in),
        .out_valid(ov1), .out_ready(1'b1), .a_out(a1), .carry_mismatch(m1)
    );
    reversible_serial_unadder #(.WIDTH(32), .DIGIT(32)) d32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32),
        .sum_in(sum_in), .b_in(b_in), .cin_in(cin_in), .cout_in(cout_in),
        .out_valid(ov32), .out_ready(1'b1), .a_out(a32), .carry_mismatch(m32)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // forward adder: Sum/Cout from a random A, optionally corrupting the claimed Cout
    task automatic new_op;
        logic [32:0] fwd;
        ra   = $urandom;
        rb   = $urandom;
        rc   = 1'($urandom_range(0, 1));
        flip = ($urandom_range(0, 7) == 0);
        fwd  = {1'b0, ra} + {1'b0, rb} + 33'(rc);
        sum_in  = fwd[31:0];
        b_in    = rb;
        cin_in  = rc;
        cout_in = fwd[32] ^ flip;
    endtask

    task automatic run_op(input string tag, input logic [31:0] s, input logic [31:0] b,
                          input logic ci, input logic co, input logic [31:0] ea, input logic em);
        int lat;
        sum_in = s; b_in = b; cin_in = ci; cout_in = co;
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 64) begin
            tick;
            lat++;
        end
        chk({tag, "_latency"}, lat, N);
        chk({tag, "_a"}, a_out, ea);
        chk({tag, "_mismatch"}, carry_mismatch, em);
    endtask

    task automatic release_op(input string tag, input logic [31:0] ea, input logic em);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk({tag, "_rel_valid"}, out_valid, 0);
        chk({tag, "_rel_ready"}, in_ready, 1);
        chk({tag, "_rel_a"}, a_out, ea);
        chk({tag, "_rel_mis"}, carry_mismatch, em);
    endtask

    initial begin
        logic [31:0] qa[$];
        bit qm[$];
        int acc_n, cyc, last_acc, stalls, l1, l32;
        bit took, prev_ov, bad;
        logic [31:0] ga1, ga32;
        logic gm1, gm32;
        repeat (2) tick;
        rst = 1'b0;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_a", a_out, 0);
        chk("reset_mismatch", carry_mismatch, 0);

        run_op("basic", 32'h8, 32'h3, 1'b0, 1'b0, 32'h5, 1'b0);
        release_op("basic", 32'h5, 1'b0);
        run_op("wrap", 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0, 1'b0);
        release_op("wrap", 32'h0, 1'b0);
        run_op("wrap_bad", 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 1'b1);

        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            bad |= !out_valid || in_ready || a_out !== 32'h0 || carry_mismatch !== 1'b1;
        end
        chk("backpressure_stable", bad, 0);
        release_op("backpressure", 32'h0, 1'b1);

        run_op("pre_abort", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h0123_4567, 1'b0);
        release_op("pre_abort", 32'h0123_4567, 1'b0);
        sum_in = 32'hDEAD_BEEF; b_in = 32'h1; cin_in = 1'b0; cout_in = 1'b0;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (2) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_a", a_out, 0);
        chk("abort_mismatch", carry_mismatch, 0);
        bad = 1'b0;
        for (int i = 0; i < N + 4; i++) begin
            tick;
            bad |= out_valid || a_out !== 32'h0;
        end
        chk("abort_no_stale", bad, 0);

        acc_n = 0; cyc = 0; last_acc = -1; stalls = 0; prev_ov = 1'b0;
        new_op;
        while ((acc_n < 1000 || qa.size() != 0) && cyc < 40000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = acc_n < 1000;
            took = in_valid && in_ready;
            if (out_valid && !prev_ov) chk("rand_latency", cyc - last_acc, N);
            if (took) begin
                if (last_acc >= 0) chk("rand_interval", cyc + 1 - last_acc, N + 2 + stalls);
                stalls = 0;
                last_acc = cyc + 1;
                qa.push_back(ra);
                qm.push_back(flip);
                acc_n++;
            end
            if (out_valid && !out_ready) stalls++;
            if (out_valid && out_ready) begin
                if (qa.size() == 0) chk("rand_unexpected_result", 1, 0);
                else begin
                    chk("rand_a", a_out, qa.pop_front());
                    chk("rand_mismatch", carry_mismatch, qm.pop_front());
                end
            end
            prev_ov = out_valid;
            tick;
            cyc++;
            if (took) new_op;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("rand_budget", cyc < 40000, 1);
        chk("rand_accepts", acc_n, 1000);

        for (int i = 0; i < 20; i++) begin
            new_op;
            chk("sweep_ready", {rdy1, rdy32}, 2'b11);
            v1 = 1'b1; v32 = 1'b1;
            tick;
            v1 = 1'b0; v32 = 1'b0;
            l1 = -1; l32 = -1; ga1 = '0; ga32 = '0; gm1 = 1'b0; gm32 = 1'b0;
            for (int k = 1; k <= 40; k++) begin
                tick;
                if (ov1 && l1 < 0) begin l1 = k; ga1 = a1; gm1 = m1; end
                if (ov32 && l32 < 0) begin l32 = k; ga32 = a32; gm32 = m32; end
            end
            chk("sweep_d1_latency", l1, 32);
            chk("sweep_d32_latency", l32, 1);
            chk("sweep_d1_a", ga1, ra);
            chk("sweep_d32_a", ga32, ra);
            chk("sweep_d1_mis", gm1, flip);
            chk("sweep_d32_mis", gm32, flip);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
